// File: rtl/fp_writeback_arbiter.sv
//------------------------------------------------------------------------------
// fp_writeback_arbiter : merges fast-path and div/sqrt results into one
// registered FP register-file write; tracks pending destinations and fflags.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module fp_writeback_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W        = 3
) (
  input  logic        clk_i,
  input  logic        rst_i,

  input  logic        fast_valid_i,
  input  logic [4:0]  fast_rd_i,
  input  logic [31:0] fast_data_i,
  input  logic [4:0]  fast_flags_i,

  input  logic        slow_valid_i,
  output logic        slow_ready_o,
  input  logic [4:0]  slow_rd_i,
  input  logic [31:0] slow_data_i,
  input  logic [4:0]  slow_flags_i,

  input  logic        issue_valid_i,
  input  logic [4:0]  issue_rd_i,
  input  logic [4:0]  issue_rs1_i,
  input  logic [4:0]  issue_rs2_i,
  input  logic [4:0]  issue_rs3_i,
  output logic        issue_hazard_o,
  output logic        stall_issue_o,

  output logic        fregwrite_o,
  output logic [4:0]  frd_o,
  output logic [31:0] wb_data_o,
  output logic [4:0]  fflags_o,
  input  logic        fflags_clr_i
);

  localparam logic [CNT_W-1:0] C_STARVE_LIMIT = CNT_W'(STARVE_LIMIT);

  logic             slow_vld_q, slow_vld_d;
  logic [4:0]       slow_rd_q;
  logic [31:0]      slow_data_q;
  logic [4:0]       slow_flags_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      pending_q, pending_d;
  logic             fregwrite_q;
  logic [4:0]       frd_q;
  logic [31:0]      wb_data_q;
  logic [4:0]       fflags_q, fflags_d;

  logic             w_slow_hs;
  logic             w_sel;
  logic             w_sel_slow;
  logic [4:0]       w_sel_rd;
  logic [31:0]      w_sel_data;
  logic [4:0]       w_sel_flags;
  logic [31:0]      w_set_mask;
  logic [31:0]      w_clr_mask;

  assign slow_ready_o  = !slow_vld_q;
  assign w_slow_hs     = slow_valid_i && !slow_vld_q;
  assign stall_issue_o = (cnt_q >= C_STARVE_LIMIT);

  assign issue_hazard_o = pending_q[issue_rs1_i] | pending_q[issue_rs2_i] |
                          pending_q[issue_rs3_i] | pending_q[issue_rd_i];

  assign fregwrite_o = fregwrite_q;
  assign frd_o       = frd_q;
  assign wb_data_o   = wb_data_q;
  assign fflags_o    = fflags_q;

  // Fast path has no back-pressure, so it always takes priority.
  always_comb begin
    w_sel       = 1'b0;
    w_sel_slow  = 1'b0;
    w_sel_rd    = 5'd0;
    w_sel_data  = 32'd0;
    w_sel_flags = 5'd0;
    if (fast_valid_i) begin
      w_sel       = 1'b1;
      w_sel_rd    = fast_rd_i;
      w_sel_data  = fast_data_i;
      w_sel_flags = fast_flags_i;
    end else if (slow_vld_q) begin
      w_sel       = 1'b1;
      w_sel_slow  = 1'b1;
      w_sel_rd    = slow_rd_q;
      w_sel_data  = slow_data_q;
      w_sel_flags = slow_flags_q;
    end
  end

  always_comb begin
    slow_vld_d = slow_vld_q;
    if (w_sel_slow) begin
      slow_vld_d = 1'b0;
    end else if (w_slow_hs) begin
      slow_vld_d = 1'b1;
    end

    cnt_d = '0;
    if (slow_vld_q && fast_valid_i) begin
      cnt_d = (cnt_q >= C_STARVE_LIMIT) ? cnt_q : cnt_q + 1'b1;
    end

    // Set is applied after clear so a same-register reissue stays pending.
    w_set_mask = '0;
    w_clr_mask = '0;
    if (issue_valid_i && !stall_issue_o) begin
      w_set_mask[issue_rd_i] = 1'b1;
    end
    if (w_sel) begin
      w_clr_mask[w_sel_rd] = 1'b1;
    end
    pending_d = (pending_q & ~w_clr_mask) | w_set_mask;

    fflags_d = fflags_clr_i ? 5'd0 : fflags_q;
    if (w_sel) begin
      fflags_d = fflags_d | w_sel_flags;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      slow_vld_q   <= 1'b0;
      slow_rd_q    <= 5'd0;
      slow_data_q  <= 32'd0;
      slow_flags_q <= 5'd0;
      cnt_q        <= '0;
      pending_q    <= '0;
      fregwrite_q  <= 1'b0;
      frd_q        <= 5'd0;
      wb_data_q    <= 32'd0;
      fflags_q     <= 5'd0;
    end else begin
      slow_vld_q <= slow_vld_d;
      if (w_slow_hs) begin
        slow_rd_q    <= slow_rd_i;
        slow_data_q  <= slow_data_i;
        slow_flags_q <= slow_flags_i;
      end
      cnt_q       <= cnt_d;
      pending_q   <= pending_d;
      fregwrite_q <= w_sel;
      if (w_sel) begin
        frd_q     <= w_sel_rd;
        wb_data_q <= w_sel_data;
      end
      fflags_q <= fflags_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_fp_writeback_arbiter.sv
//------------------------------------------------------------------------------
// tb_fp_writeback_arbiter : directed self-checking bench for the FP writeback
// arbiter. Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_fp_writeback_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        fast_valid = 1'b0;
  logic [4:0]  fast_rd = 5'd0;
  logic [31:0] fast_data = 32'd0;
  logic [4:0]  fast_flags = 5'd0;
  logic        slow_valid = 1'b0;
  logic        slow_ready;
  logic [4:0]  slow_rd = 5'd0;
  logic [31:0] slow_data = 32'd0;
  logic [4:0]  slow_flags = 5'd0;
  logic        issue_valid = 1'b0;
  logic [4:0]  issue_rd = 5'd0;
  logic [4:0]  issue_rs1 = 5'd0;
  logic [4:0]  issue_rs2 = 5'd0;
  logic [4:0]  issue_rs3 = 5'd0;
  logic        issue_hazard;
  logic        stall_issue;
  logic        fregwrite;
  logic [4:0]  frd;
  logic [31:0] wb_data;
  logic [4:0]  fflags;
  logic        fflags_clr = 1'b0;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  fp_writeback_arbiter #(.STARVE_LIMIT(4), .CNT_W(3)) dut (
    .clk_i(clk), .rst_i(rst),
    .fast_valid_i(fast_valid), .fast_rd_i(fast_rd), .fast_data_i(fast_data),
    .fast_flags_i(fast_flags),
    .slow_valid_i(slow_valid), .slow_ready_o(slow_ready), .slow_rd_i(slow_rd),
    .slow_data_i(slow_data), .slow_flags_i(slow_flags),
    .issue_valid_i(issue_valid), .issue_rd_i(issue_rd), .issue_rs1_i(issue_rs1),
    .issue_rs2_i(issue_rs2), .issue_rs3_i(issue_rs3),
    .issue_hazard_o(issue_hazard), .stall_issue_o(stall_issue),
    .fregwrite_o(fregwrite), .frd_o(frd), .wb_data_o(wb_data),
    .fflags_o(fflags), .fflags_clr_i(fflags_clr)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_srcs(input logic [4:0] r);
    issue_rd  = r;
    issue_rs1 = r;
    issue_rs2 = r;
    issue_rs3 = r;
    #1;
  endtask

  initial begin
    // 1: reset and idle
    tick();
    tick();
    rst = 1'b0;
    tick();
    check("rst_fregwrite", 32'(fregwrite), 32'd0);
    check("rst_frd", 32'(frd), 32'd0);
    check("rst_wb_data", wb_data, 32'd0);
    check("rst_fflags", 32'(fflags), 32'd0);
    check("rst_slow_ready", 32'(slow_ready), 32'd1);
    check("rst_stall", 32'(stall_issue), 32'd0);
    for (int r = 0; r < 32; r++) begin
      set_srcs(5'(r));
      check("rst_pending", 32'(issue_hazard), 32'd0);
    end

    // 2: single fast write clearing a pending destination
    issue_valid = 1'b1;
    issue_rd = 5'd5;
    tick();
    issue_valid = 1'b0;
    set_srcs(5'd5);
    check("sb_set5", 32'(issue_hazard), 32'd1);
    fast_valid = 1'b1; fast_rd = 5'd5; fast_data = 32'h3F800000; fast_flags = 5'b00001;
    #1;
    check("sb_hold5_presel", 32'(issue_hazard), 32'd1);
    tick();
    fast_valid = 1'b0;
    #1;
    check("fast_fregwrite", 32'(fregwrite), 32'd1);
    check("fast_frd", 32'(frd), 32'd5);
    check("fast_data", wb_data, 32'h3F800000);
    check("fast_fflags", 32'(fflags), 32'd1);
    check("sb_clr5", 32'(issue_hazard), 32'd0);
    tick();
    check("idle_fregwrite", 32'(fregwrite), 32'd0);
    check("idle_frd_hold", 32'(frd), 32'd5);
    check("idle_data_hold", wb_data, 32'h3F800000);

    // 3: slow handshake colliding with two fast results
    slow_valid = 1'b1; slow_rd = 5'd7; slow_data = 32'h40490FDB; slow_flags = 5'b00100;
    #1;
    check("col_ready_N", 32'(slow_ready), 32'd1);
    tick();
    slow_valid = 1'b0;
    fast_valid = 1'b1; fast_rd = 5'd1; fast_data = 32'hAAAA0001; fast_flags = 5'd0;
    #1;
    check("col_ready_N1", 32'(slow_ready), 32'd0);
    tick();
    fast_rd = 5'd2; fast_data = 32'hBBBB0002;
    #1;
    check("col_N2_we", 32'(fregwrite), 32'd1);
    check("col_N2_frd", 32'(frd), 32'd1);
    check("col_N2_data", wb_data, 32'hAAAA0001);
    tick();
    fast_valid = 1'b0;
    #1;
    check("col_N3_frd", 32'(frd), 32'd2);
    check("col_N3_data", wb_data, 32'hBBBB0002);
    check("col_N3_ready", 32'(slow_ready), 32'd0);
    tick();
    check("col_N4_we", 32'(fregwrite), 32'd1);
    check("col_N4_frd", 32'(frd), 32'd7);
    check("col_N4_data", wb_data, 32'h40490FDB);
    check("col_N4_ready", 32'(slow_ready), 32'd1);
    check("col_N4_fflags", 32'(fflags), 32'b00101);
    tick();
    check("col_N5_we", 32'(fregwrite), 32'd0);

    // 4: starvation of a buffered slow result
    fflags_clr = 1'b1;
    tick();
    fflags_clr = 1'b0;
    check("clr_idle", 32'(fflags), 32'd0);
    slow_valid = 1'b1; slow_rd = 5'd9; slow_data = 32'h12345678; slow_flags = 5'd0;
    fast_valid = 1'b1; fast_rd = 5'd10; fast_data = 32'h0000000A; fast_flags = 5'd0;
    tick();
    slow_valid = 1'b0;
    #1;
    check("stv_stall0", 32'(stall_issue), 32'd0);
    for (int i = 1; i <= 4; i++) begin
      tick();
      check("stv_stall", 32'(stall_issue), (i == 4) ? 32'd1 : 32'd0);
      check("stv_fast_we", 32'(frd), 32'd10);
    end
    fast_valid = 1'b0;
    issue_valid = 1'b1; issue_rd = 5'd20;
    tick();
    issue_valid = 1'b0;
    check("stv_slow_frd", 32'(frd), 32'd9);
    check("stv_slow_data", wb_data, 32'h12345678);
    check("stv_stall_fall", 32'(stall_issue), 32'd0);
    set_srcs(5'd20);
    check("stv_issue_blocked", 32'(issue_hazard), 32'd0);

    // 5: scoreboard hazards, same-cycle set/clear, f0
    issue_valid = 1'b1; issue_rd = 5'd3;
    tick();
    issue_valid = 1'b0;
    issue_rd = 5'd4; issue_rs1 = 5'd4; issue_rs2 = 5'd3; issue_rs3 = 5'd4;
    #1;
    check("sb_rs2_haz", 32'(issue_hazard), 32'd1);
    issue_rs2 = 5'd4;
    #1;
    check("sb_nohaz", 32'(issue_hazard), 32'd0);
    fast_valid = 1'b1; fast_rd = 5'd3; fast_data = 32'h33333333;
    issue_valid = 1'b1; issue_rd = 5'd3;
    tick();
    fast_valid = 1'b0; issue_valid = 1'b0;
    set_srcs(5'd3);
    check("sb_set_wins", 32'(issue_hazard), 32'd1);
    fast_valid = 1'b1;
    tick();
    fast_valid = 1'b0;
    #1;
    check("sb_clr3", 32'(issue_hazard), 32'd0);
    issue_valid = 1'b1; issue_rd = 5'd0;
    tick();
    issue_valid = 1'b0;
    set_srcs(5'd0);
    check("sb_f0_set", 32'(issue_hazard), 32'd1);
    fast_valid = 1'b1; fast_rd = 5'd0;
    tick();
    fast_valid = 1'b0;
    #1;
    check("sb_f0_clr", 32'(issue_hazard), 32'd0);

    // 6: fflags accumulation / clear, reset mid-slow-transaction
    fflags_clr = 1'b1;
    tick();
    fflags_clr = 1'b0;
    fast_valid = 1'b1; fast_rd = 5'd12; fast_flags = 5'b10000;
    tick();
    check("ff_acc1", 32'(fflags), 32'b10000);
    fast_flags = 5'b00010;
    tick();
    check("ff_acc2", 32'(fflags), 32'b10010);
    fast_flags = 5'b00001; fflags_clr = 1'b1;
    tick();
    check("ff_clr_write", 32'(fflags), 32'b00001);
    fast_valid = 1'b0; fast_flags = 5'd0;
    tick();
    fflags_clr = 1'b0;
    check("ff_clr_idle", 32'(fflags), 32'd0);

    issue_valid = 1'b1; issue_rd = 5'd25;
    slow_valid = 1'b1; slow_rd = 5'd11; slow_data = 32'hDEADBEEF; slow_flags = 5'b11111;
    tick();
    issue_valid = 1'b0; slow_valid = 1'b0;
    check("rstm_buf_full", 32'(slow_ready), 32'd0);
    rst = 1'b1;
    fast_valid = 1'b1; fast_rd = 5'd13; fast_data = 32'h13131313; fast_flags = 5'b01000;
    tick();
    rst = 1'b0; fast_valid = 1'b0; fast_flags = 5'd0;
    #1;
    check("rstm_we", 32'(fregwrite), 32'd0);
    check("rstm_frd", 32'(frd), 32'd0);
    check("rstm_data", wb_data, 32'd0);
    check("rstm_fflags", 32'(fflags), 32'd0);
    check("rstm_ready", 32'(slow_ready), 32'd1);
    set_srcs(5'd25);
    check("rstm_pending", 32'(issue_hazard), 32'd0);
    tick();
    check("rstm_no_slow", 32'(fregwrite), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
